tag_sort_queue: RTL and testbench
=================================

# tag_sort_queue

Parametrised sorted-tag scheduler queue for the packet scheduler datapath. It holds up to DEPTH packet descriptors (tag, packet id, SPB address) kept in ascending tag order. On request it releases the smallest-tag descriptor. It adds three things the single-size tag circuit lacks: wrap-around tag comparison, same-cycle insert plus pop, and a defined full-queue eviction policy.

## Interface
- T, 12, tag width in bits
- S, 13, SPB address width
- I, 13, packet id width
- DEPTH, 16, number of slots; must be at least 2, and need not be a power of two
- WRAP, 1; 1 = modulo-2^T serial comparison, 0 = plain unsigned comparison
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- ins_valid  in  1  insert the descriptor present this cycle
- ins_tag / ins_id / ins_addr  in  T / I / S  descriptor to insert
- pop_req  in  1  release the head descriptor
- pop_valid  out  1  one-cycle pulse; out_* valid
- out_tag / out_id / out_addr  out  T / I / S  released descriptor; holds its value between pops
- head_tag / head_id  out  T / I  current slot 0; valid only when !empty
- count  out  $clog2(DEPTH+1)  occupied slots
- full / empty  out  1  count==DEPTH / count==0
- drop_pulse  out  1  one-cycle pulse; a descriptor was discarded
- drop_id  out  I  id of the discarded descriptor

## Operation
- Slots 0..DEPTH-1 are kept sorted. Slot 0 always holds the earliest tag. Occupied slots are contiguous from slot 0.
- Ordering function before(a,b):
  - WRAP=1: MSB of (a-b) mod 2^T is set.
  - WRAP=0: a<b.
  - Equal tags never precede each other.
- Insert position p = number of occupied slots s where !before(ins_tag, tag[s]). Ties therefore insert after existing equal tags, giving FIFO order among equal tags.
- Insert only: slots p..count-1 shift up by one, the new descriptor goes into slot p, count+1.
- Pop only, with !empty: slot 0 goes to out_*, slots shift down by one, count-1.
- Pop with empty: ignored. No pop_valid, no count change.
- Insert and pop together, with !empty: the old slot 0 is released. The new descriptor lands at max(p-1,0) in the post-shift array. count is unchanged and no drop occurs, even when full.
- Insert and pop with empty: the pop is ignored and the insert proceeds, so count becomes 1.
- Insert while full, without pop:
  - If p<DEPTH: the tail (slot DEPTH-1) is evicted, the new descriptor is inserted, drop_pulse=1, drop_id = evicted id.
  - If p==DEPTH: the new descriptor is rejected, drop_pulse=1, drop_id = ins_id.
  - count stays DEPTH in both cases.
- With WRAP=1, ordering is correct only while live tags span less than 2^(T-1). Upstream guarantees this; the block does not check it.

## Timing
- Reset: all slots invalid; count=0, empty=1, full=0, pop_valid=0, drop_pulse=0; out_*, head_*, drop_id all 0.
- Pop latency is 1 cycle. pop_req sampled at edge k gives pop_valid=1 and out_* during cycle k+1.
- An insert at edge k is reflected in head_*, count, full and empty in cycle k+1. It can therefore be popped by a pop_req sampled at edge k+1 at the earliest.
- Back-to-back operation is allowed every cycle for both inserts and pops. There is no ready/backpressure; overflow is handled only by the drop policy.
- All outputs are registered. No combinational path runs from inputs to outputs.
- Reset asserted mid-operation clears all contents immediately. No pulse is emitted during or after the reset.

## Structure
- Package tag_sort_pkg holds:
  - the descriptor struct typedef {tag, id, addr, valid}, parametrised by T/I/S via the module's localparam types
  - the function tag_before(a, b, wrap).
- Sub-module tag_sort_cell is one slot. Inputs: own and neighbour descriptors, the insert descriptor, a shared insert/pop control. It computes its local comparison and selects among keep, take-left, take-right and take-new.
- The top level holds DEPTH cells in a generate loop, plus the count, flag, output and drop registers.

## Test plan
- Reset, then insert tags 1000, 1100, …, 1700 (ids 1–8), then 8 pops → ids released 1..8 in order; empty=1 after the last pop; a 9th pop produces no pop_valid.
- Insert 1200, 900, 1700, 700 (ids 10–13), then 4 pops → ids 13, 11, 10, 12.
- WRAP=1, T=12: insert 4090 (id 1), then 5 (id 2), then pop → id 1 first. Repeat with WRAP=0 → id 2 first.
- Insert tag 500 three times (ids 1, 2, 3), then 3 pops → ids 1, 2, 3, confirming FIFO tie order.
- DEPTH=4, queue full with 100/200/300/400:
  - insert 150 → drop_id = id of 400; contents 100/150/200/300.
  - insert 999 → drop_id = the new id; contents unchanged.
- Full queue, then insert 50 together with pop in the same cycle → the old head (100) is released, no drop_pulse, count stays 4, head_tag=50 next cycle. Separately, assert rst mid-stream → count=0 and empty=1 immediately.

Source files
------------

// File: rtl/tag_sort_pkg.sv
// Shared operation/select encodings and the tag ordering function for the sorted-tag queue.
package tag_sort_pkg;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_INS,
        OP_POP,
        OP_INSPOP
    } op_e;

    typedef enum logic [1:0] {
        SEL_KEEP,
        SEL_LEFT,
        SEL_RIGHT,
        SEL_NEW
    } sel_e;

    // Serial-number comparison keeps only bit w-1 of the difference, so wider garbage is harmless.
    function automatic logic tag_before(input logic [31:0] a, input logic [31:0] b,
                                        input int unsigned w, input logic wrap);
        logic [31:0] diff;
        diff = a - b;
        if (wrap) return |(diff & (32'd1 << (w - 1)));
        return a < b;
    endfunction

endpackage

// File: rtl/tag_sort_cell.sv
// One queue slot: registers a descriptor and picks keep/left/right/new from the shared operation.
module tag_sort_cell
    import tag_sort_pkg::*;
#(
    parameter int unsigned T     = 12,
    parameter int unsigned I     = 13,
    parameter int unsigned S     = 13,
    parameter int unsigned WRAP  = 1,
    parameter bit          FIRST = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  op_e            op_i,
    input  logic [T+I+S:0] new_i,
    input  logic [T+I+S:0] left_i,
    input  logic [T+I+S:0] right_i,
    input  logic           left_ge_i,
    input  logic           right_ge_i,
    output logic           ge_o,
    output logic [T+I+S:0] slot_o
);

    typedef struct packed {
        logic [T-1:0] tag;
        logic [I-1:0] id;
        logic [S-1:0] addr;
        logic         valid;
    } desc_t;

    desc_t new_d, slot_q, slot_d;
    sel_e  sel;

    assign new_d  = new_i;
    assign slot_o = slot_q;

    // Set when the incoming descriptor belongs behind this slot (ties go behind).
    assign ge_o = slot_q.valid &&
                  !tag_before(32'(new_d.tag), 32'(slot_q.tag), T, WRAP != 0);

    // Insert+pop: the array is viewed after the pop shift, so positions are judged one slot right.
    always_comb begin
        sel = SEL_KEEP;
        unique case (op_i)
            OP_INS: begin
                if (ge_o)           sel = SEL_KEEP;
                else if (left_ge_i) sel = SEL_NEW;
                else                sel = SEL_LEFT;
            end
            OP_POP: sel = SEL_RIGHT;
            OP_INSPOP: begin
                if (right_ge_i)           sel = SEL_RIGHT;
                else if (ge_o || FIRST)   sel = SEL_NEW;
                else                      sel = SEL_KEEP;
            end
            default: sel = SEL_KEEP;
        endcase
    end

    always_comb begin
        slot_d = slot_q;
        unique case (sel)
            SEL_LEFT:  slot_d = left_i;
            SEL_RIGHT: slot_d = right_i;
            SEL_NEW:   slot_d = new_d;
            default:   slot_d = slot_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) slot_q <= '0;
        else      slot_q <= slot_d;
    end

endmodule

// File: rtl/tag_sort_queue.sv
// Sorted-tag scheduler queue: DEPTH slot cells plus count, pop-output and drop registers.
module tag_sort_queue
    import tag_sort_pkg::*;
#(
    parameter int unsigned T     = 12,
    parameter int unsigned S     = 13,
    parameter int unsigned I     = 13,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WRAP  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ins_valid,
    input  logic [T-1:0]               ins_tag,
    input  logic [I-1:0]               ins_id,
    input  logic [S-1:0]               ins_addr,
    input  logic                       pop_req,
    output logic                       pop_valid,
    output logic [T-1:0]               out_tag,
    output logic [I-1:0]               out_id,
    output logic [S-1:0]               out_addr,
    output logic [T-1:0]               head_tag,
    output logic [I-1:0]               head_id,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       drop_pulse,
    output logic [I-1:0]               drop_id
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [T-1:0] tag;
        logic [I-1:0] id;
        logic [S-1:0] addr;
        logic         valid;
    } desc_t;

    // Index 0 and DEPTH+1 are empty sentinels flanking the cells at 1..DEPTH.
    desc_t dw [DEPTH+2];
    logic  gw [DEPTH+2];
    desc_t ins_desc;
    op_e   op;
    logic  pop_eff;

    logic [CW-1:0] count_q, count_d;
    logic          pop_valid_q, pop_valid_d;
    logic [T-1:0]  out_tag_q, out_tag_d;
    logic [I-1:0]  out_id_q, out_id_d;
    logic [S-1:0]  out_addr_q, out_addr_d;
    logic          drop_pulse_q, drop_pulse_d;
    logic [I-1:0]  drop_id_q, drop_id_d;

    assign ins_desc    = '{tag: ins_tag, id: ins_id, addr: ins_addr, valid: 1'b1};
    assign dw[0]       = '0;
    assign dw[DEPTH+1] = '0;
    assign gw[0]       = 1'b1;
    assign gw[DEPTH+1] = 1'b0;

    for (genvar s = 0; s < DEPTH; s++) begin : g_slot
        tag_sort_cell #(
            .T(T), .I(I), .S(S), .WRAP(WRAP), .FIRST(s == 0)
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .op_i      (op),
            .new_i     (ins_desc),
            .left_i    (dw[s]),
            .right_i   (dw[s+2]),
            .left_ge_i (gw[s]),
            .right_ge_i(gw[s+2]),
            .ge_o      (gw[s+1]),
            .slot_o    (dw[s+1])
        );
    end

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_eff = pop_req && !empty;

    always_comb begin
        op = OP_IDLE;
        if (ins_valid && pop_eff) op = OP_INSPOP;
        else if (ins_valid)       op = OP_INS;
        else if (pop_eff)         op = OP_POP;
    end

    always_comb begin
        count_d      = count_q;
        pop_valid_d  = 1'b0;
        out_tag_d    = out_tag_q;
        out_id_d     = out_id_q;
        out_addr_d   = out_addr_q;
        drop_pulse_d = 1'b0;
        drop_id_d    = drop_id_q;
        unique case (op)
            OP_INS: begin
                if (!full) begin
                    count_d = count_q + CW'(1);
                end else begin
                    // Tail belongs behind the newcomer unless the newcomer sorts past every slot.
                    drop_pulse_d = 1'b1;
                    drop_id_d    = gw[DEPTH] ? ins_id : dw[DEPTH].id;
                end
            end
            OP_POP, OP_INSPOP: begin
                if (op == OP_POP) count_d = count_q - CW'(1);
                pop_valid_d = 1'b1;
                out_tag_d   = dw[1].tag;
                out_id_d    = dw[1].id;
                out_addr_d  = dw[1].addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q      <= '0;
            pop_valid_q  <= 1'b0;
            out_tag_q    <= '0;
            out_id_q     <= '0;
            out_addr_q   <= '0;
            drop_pulse_q <= 1'b0;
            drop_id_q    <= '0;
        end else begin
            count_q      <= count_d;
            pop_valid_q  <= pop_valid_d;
            out_tag_q    <= out_tag_d;
            out_id_q     <= out_id_d;
            out_addr_q   <= out_addr_d;
            drop_pulse_q <= drop_pulse_d;
            drop_id_q    <= drop_id_d;
        end
    end

    assign count      = count_q;
    assign pop_valid  = pop_valid_q;
    assign out_tag    = out_tag_q;
    assign out_id     = out_id_q;
    assign out_addr   = out_addr_q;
    assign head_tag   = dw[1].tag;
    assign head_id    = dw[1].id;
    assign drop_pulse = drop_pulse_q;
    assign drop_id    = drop_id_q;

endmodule

// File: tb/tb_tag_sort_queue.sv
// Directed bench: three queues (wrap/16, plain/16, wrap/4) driven by one shared stimulus stream.
module tb_tag_sort_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ins_valid = 1'b0;
    logic        pop_req = 1'b0;
    logic [11:0] ins_tag = '0;
    logic [12:0] ins_id = '0;
    logic [12:0] ins_addr = '0;

    logic        pv_a, fu_a, em_a, dp_a;
    logic [11:0] ot_a, ht_a;
    logic [12:0] oi_a, oa_a, hi_a, di_a;
    logic [4:0]  cn_a;

    logic        pv_b, fu_b, em_b, dp_b;
    logic [11:0] ot_b, ht_b;
    logic [12:0] oi_b, oa_b, hi_b, di_b;
    logic [4:0]  cn_b;

    logic        pv_c, fu_c, em_c, dp_c;
    logic [11:0] ot_c, ht_c;
    logic [12:0] oi_c, oa_c, hi_c, di_c;
    logic [2:0]  cn_c;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    tag_sort_queue #(.T(12), .S(13), .I(13), .DEPTH(16), .WRAP(1)) u_a (
        .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_tag(ins_tag), .ins_id(ins_id),
        .ins_addr(ins_addr), .pop_req(pop_req), .pop_valid(pv_a), .out_tag(ot_a),
        .out_id(oi_a), .out_addr(oa_a), .head_tag(ht_a), .head_id(hi_a), .count(cn_a),
        .full(fu_a), .empty(em_a), .drop_pulse(dp_a), .drop_id(di_a)
    );

    tag_sort_queue #(.T(12), .S(13), .I(13), .DEPTH(16), .WRAP(0)) u_b (
        .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_tag(ins_tag), .ins_id(ins_id),
        .ins_addr(ins_addr), .pop_req(pop_req), .pop_valid(pv_b), .out_tag(ot_b),
        .out_id(oi_b), .out_addr(oa_b), .head_tag(ht_b), .head_id(hi_b), .count(cn_b),
        .full(fu_b), .empty(em_b), .drop_pulse(dp_b), .drop_id(di_b)
    );

    tag_sort_queue #(.T(12), .S(13), .I(13), .DEPTH(4), .WRAP(1)) u_c (
        .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_tag(ins_tag), .ins_id(ins_id),
        .ins_addr(ins_addr), .pop_req(pop_req), .pop_valid(pv_c), .out_tag(ot_c),
        .out_id(oi_c), .out_addr(oa_c), .head_tag(ht_c), .head_id(hi_c), .count(cn_c),
        .full(fu_c), .empty(em_c), .drop_pulse(dp_c), .drop_id(di_c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", name, got, exp);
    endtask

    // Drive one cycle of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic iv, input int tag, input int id, input logic pr);
        ins_valid = iv;
        ins_tag   = 12'(tag);
        ins_id    = 13'(id);
        ins_addr  = 13'(id + 100);
        pop_req   = pr;
        @(posedge clk);
        #1;
        ins_valid = 1'b0;
        pop_req   = 1'b0;
    endtask

    initial begin
        int exp_id2 [4];
        int exp_tg2 [4];
        exp_id2 = '{13, 11, 10, 12};
        exp_tg2 = '{700, 900, 1200, 1700};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(cn_a), 0);
        chk("rst_empty", 32'(em_a), 1);
        chk("rst_full", 32'(fu_a), 0);
        chk("rst_pop_valid", 32'(pv_a), 0);
        chk("rst_drop", 32'(dp_a), 0);
        chk("rst_out_id", 32'(oi_a), 0);
        chk("rst_head_tag", 32'(ht_a), 0);
        chk("rst_count_c", 32'(cn_c), 0);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) cyc(1'b1, 1000 + 100 * i, i + 1, 1'b0);
        chk("seq_count", 32'(cn_a), 8);
        chk("seq_head_tag", 32'(ht_a), 1000);
        chk("seq_head_id", 32'(hi_a), 1);
        chk("seq_full", 32'(fu_a), 0);
        chk("seq_full_c", 32'(fu_c), 1);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 0, 0, 1'b1);
            chk("seq_pop_valid", 32'(pv_a), 1);
            chk("seq_pop_id", 32'(oi_a), i + 1);
            chk("seq_pop_tag", 32'(ot_a), 1000 + 100 * i);
            chk("seq_pop_addr", 32'(oa_a), i + 101);
        end
        chk("seq_empty", 32'(em_a), 1);
        cyc(1'b0, 0, 0, 1'b1);
        chk("empty_pop_valid", 32'(pv_a), 0);
        chk("empty_pop_count", 32'(cn_a), 0);
        chk("empty_pop_hold_id", 32'(oi_a), 8);

        cyc(1'b1, 1200, 10, 1'b0);
        cyc(1'b1, 900, 11, 1'b0);
        cyc(1'b1, 1700, 12, 1'b0);
        cyc(1'b1, 700, 13, 1'b0);
        chk("mix_head_id", 32'(hi_a), 13);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 0, 0, 1'b1);
            chk("mix_pop_id", 32'(oi_a), exp_id2[i]);
            chk("mix_pop_tag", 32'(ot_a), exp_tg2[i]);
            chk("mix_pop_id_plain", 32'(oi_b), exp_id2[i]);
        end

        cyc(1'b1, 4090, 1, 1'b0);
        cyc(1'b1, 5, 2, 1'b0);
        cyc(1'b0, 0, 0, 1'b1);
        chk("wrap1_first_id", 32'(oi_a), 1);
        chk("wrap1_first_tag", 32'(ot_a), 4090);
        chk("wrap0_first_id", 32'(oi_b), 2);
        chk("wrap0_first_tag", 32'(ot_b), 5);
        cyc(1'b0, 0, 0, 1'b1);
        chk("wrap1_second_id", 32'(oi_a), 2);
        chk("wrap0_second_id", 32'(oi_b), 1);
        chk("wrap0_empty", 32'(em_b), 1);

        for (int i = 1; i <= 3; i++) cyc(1'b1, 500, i, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b0, 0, 0, 1'b1);
            chk("tie_pop_id", 32'(oi_a), i);
        end

        rst = 1'b0;
        cyc(1'b0, 0, 0, 1'b0);
        rst = 1'b1;
        for (int i = 1; i <= 4; i++) cyc(1'b1, 100 * i, i, 1'b0);
        chk("full_flag", 32'(fu_c), 1);
        chk("full_count", 32'(cn_c), 4);
        cyc(1'b1, 150, 5, 1'b0);
        chk("evict_pulse", 32'(dp_c), 1);
        chk("evict_id", 32'(di_c), 4);
        chk("evict_count", 32'(cn_c), 4);
        chk("evict_head", 32'(ht_c), 100);
        cyc(1'b0, 0, 0, 1'b0);
        chk("evict_pulse_clear", 32'(dp_c), 0);
        cyc(1'b1, 999, 6, 1'b0);
        chk("reject_pulse", 32'(dp_c), 1);
        chk("reject_id", 32'(di_c), 6);
        chk("reject_count", 32'(cn_c), 4);
        cyc(1'b1, 50, 7, 1'b1);
        chk("inspop_valid", 32'(pv_c), 1);
        chk("inspop_out_tag", 32'(ot_c), 100);
        chk("inspop_out_id", 32'(oi_c), 1);
        chk("inspop_no_drop", 32'(dp_c), 0);
        chk("inspop_count", 32'(cn_c), 4);
        chk("inspop_head_tag", 32'(ht_c), 50);
        begin
            int exp_id5 [4];
            int exp_tg5 [4];
            exp_id5 = '{7, 5, 2, 3};
            exp_tg5 = '{50, 150, 200, 300};
            for (int i = 0; i < 4; i++) begin
                cyc(1'b0, 0, 0, 1'b1);
                chk("drain_id", 32'(oi_c), exp_id5[i]);
                chk("drain_tag", 32'(ot_c), exp_tg5[i]);
            end
        end
        chk("drain_empty", 32'(em_c), 1);

        cyc(1'b1, 300, 9, 1'b1);
        chk("ins_pop_empty_valid", 32'(pv_c), 0);
        chk("ins_pop_empty_count", 32'(cn_c), 1);
        chk("ins_pop_empty_head", 32'(hi_c), 9);
        cyc(1'b1, 310, 10, 1'b0);
        chk("pre_reset_count", 32'(cn_c), 2);

        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_count", 32'(cn_c), 0);
        chk("async_rst_empty", 32'(em_c), 1);
        chk("async_rst_head", 32'(ht_c), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("rst_hold_pulse", 32'(dp_c), 0);
        cyc(1'b0, 0, 0, 1'b0);
        chk("post_rst_pop_valid", 32'(pv_c), 0);
        chk("post_rst_count", 32'(cn_c), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
